batt_monitor: RTL and testbench



---
 rtl/batt_monitor.sv | 224 ++++++++++++++++++++++
 tb/tb_batt_monitor.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/batt_monitor.sv
// Battery-monitor scheduler for the A2D conversion path.
// Issues strt_cnv periodically and on demand, merges concurrent requests into
// one conversion, low-pass filters the 12-bit result and maintains a
// hysteretic low-battery flag plus a sticky A2D timeout fault.
module batt_monitor #(
  parameter int          PERIOD  = 2_500_000, // cycles between automatic conversions (>= 2)
  parameter int          TIMEOUT = 4096,      // max cycles to wait for cnv_cmplt (>= 2)
  parameter logic [11:0] LOW_THR = 12'hA00,   // filtered level below which a sample is low
  parameter logic [11:0] HYST    = 12'h080,   // recovery margin above LOW_THR
  parameter int          LOW_CNT = 4          // consecutive low samples to set batt_low
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_cnv,
  output logic        req_done,
  output logic        strt_cnv,
  input  logic        cnv_cmplt,
  input  logic [11:0] res,
  output logic [11:0] batt_filt,
  output logic [7:0]  batt,
  output logic        batt_vld,
  output logic        batt_low,
  output logic        a2d_fault
);

  localparam int PW = $clog2(PERIOD);
  localparam int TW = $clog2(TIMEOUT);
  localparam int CW = $clog2(LOW_CNT + 1);

  localparam logic [PW-1:0] PER_LOAD  = PW'(PERIOD - 1);
  // The START cycle is itself the first cycle of the new period, so the
  // counter leaves START already one step down; this keeps idle auto
  // conversions exactly PERIOD cycles apart.
  localparam logic [PW-1:0] PER_START = PW'(PERIOD - 2);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] LOW_MAX   = CW'(LOW_CNT);
  localparam logic [12:0]   REC_THR   = {1'b0, LOW_THR} + {1'b0, HYST};

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_UPDATE
  } state_t;

  state_t          state;
  state_t          state_d;

  logic [PW-1:0]   per_cnt;
  logic            per_exp;
  logic            req_pend;
  logic            auto_pend;
  logic            srv_req;
  logic [TW-1:0]   tmo_cnt;
  logic [TW-1:0]   tmo_nxt;
  logic [11:0]     res_q;
  logic [CW-1:0]   low_cnt;

  logic            capture;
  logic            tmo_hit;
  logic [11:0]     filt_new;
  logic [CW-1:0]   low_cnt_new;
  logic            low_new;

  // Expiry fires in the cycle whose decrement would bring the count to 0.
  assign per_exp = (per_cnt <= PW'(1));
  assign tmo_nxt = tmo_cnt + TW'(1);
  assign batt    = batt_filt[11:4];

  // Period counter: free-running down-count, restarted by every START.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // the pre-edge values of its peers regardless of block ordering.
    if (rst) begin
      per_cnt <= PER_LOAD;
    end else if (state == S_START) begin
      per_cnt <= PER_START;
    end else if (per_exp) begin
      per_cnt <= PER_LOAD;
    end else begin
      per_cnt <= per_cnt - PW'(1);
    end
  end

  // Pending-request bits: set in any state, consumed by START unless re-set
  // in that very cycle. Multiple expiries while busy collapse into one bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_pend  <= 1'b0;
      auto_pend <= 1'b0;
      srv_req   <= 1'b0;
    end else begin
      if (req_cnv) begin
        req_pend <= 1'b1;
      end else if (state == S_START) begin
        req_pend <= 1'b0;
      end

      if (per_exp) begin
        auto_pend <= 1'b1;
      end else if (state == S_START) begin
        auto_pend <= 1'b0;
      end

      if (state == S_START) begin
        srv_req <= req_pend;
      end
    end
  end

  // Timeout counter: cleared in START, counts WAIT cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state == S_START) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT) begin
      tmo_cnt <= tmo_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // FSM next-state logic; completion wins over a same-cycle timeout.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d = state;
    capture = 1'b0;
    tmo_hit = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_pend || auto_pend) begin
          state_d = S_START;
        end
      end
      S_START: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnv_cmplt) begin
          capture = 1'b1;
          state_d = S_UPDATE;
        end else if (tmo_nxt == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_UPDATE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Conversion result capture, loaded only on a completion seen in WAIT.
  always_ff @(posedge clk) begin
    // NOTE: this data register carries no reset; it is only read in UPDATE,
    // which is reachable solely through the cycle that loads it.
    if (capture) begin
      res_q <= res;
    end
  end

  // Filter and low-detect on the captured sample.
  always_comb begin
    filt_new    = res_q;
    low_cnt_new = low_cnt;
    low_new     = batt_low;

    // First sample seeds the filter; afterwards (3*filt + res) / 4 in 14 bits.
    if (batt_vld) begin
      filt_new = 12'((({2'b00, batt_filt} << 1) + {2'b00, batt_filt} + {2'b00, res_q}) >> 2);
    end

    if (filt_new < LOW_THR) begin
      low_cnt_new = (low_cnt == LOW_MAX) ? LOW_MAX : low_cnt + CW'(1);
      if (low_cnt_new == LOW_MAX) begin
        low_new = 1'b1;
      end
    end else if ({1'b0, filt_new} >= REC_THR) begin
      low_cnt_new = '0;
      low_new     = 1'b0;
    end else begin
      // Hysteresis band: restart the low run but keep the flag as is.
      low_cnt_new = '0;
    end
  end

  // Registered outputs: start strobe, done pulse, sticky fault, filter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strt_cnv  <= 1'b0;
      req_done  <= 1'b0;
      a2d_fault <= 1'b0;
      batt_filt <= '0;
      batt_vld  <= 1'b0;
      batt_low  <= 1'b0;
      low_cnt   <= '0;
    end else begin
      strt_cnv <= (state_d == S_START);
      req_done <= srv_req && (tmo_hit || (state == S_UPDATE));
      if (tmo_hit) begin
        a2d_fault <= 1'b1;
      end
      if (state == S_UPDATE) begin
        batt_filt <= filt_new;
        batt_vld  <= 1'b1;
        batt_low  <= low_new;
        low_cnt   <= low_cnt_new;
      end
    end
  end

endmodule

// File: tb/tb_batt_monitor.sv
// Directed testbench for batt_monitor (PERIOD=100, TIMEOUT=16).
// Inputs are driven and outputs sampled on the falling edge; "cycle k"
// counts rising-edge periods from the cycle in which rst is released.
module tb_batt_monitor;

  localparam int PERIOD  = 100;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_cnv;
  logic        req_done;
  logic        strt_cnv;
  logic        cnv_cmplt;
  logic [11:0] res;
  logic [11:0] batt_filt;
  logic [7:0]  batt;
  logic        batt_vld;
  logic        batt_low;
  logic        a2d_fault;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  batt_monitor #(
    .PERIOD (PERIOD),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_cnv  (req_cnv),
    .req_done (req_done),
    .strt_cnv (strt_cnv),
    .cnv_cmplt(cnv_cmplt),
    .res      (res),
    .batt_filt(batt_filt),
    .batt     (batt),
    .batt_vld (batt_vld),
    .batt_low (batt_low),
    .a2d_fault(a2d_fault)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the falling edge of cycle 0 with rst just released.
  task automatic apply_reset;
    rst       = 1'b1;
    req_cnv   = 1'b0;
    cnv_cmplt = 1'b0;
    res       = 12'h000;
    step(2);
    rst = 1'b0;
  endtask

  // One demand conversion returning r; bounded waits on strt_cnv and req_done.
  task automatic do_conv(input logic [11:0] r);
    int n;
    req_cnv = 1'b1;
    step(1);
    req_cnv = 1'b0;
    n = 0;
    while (strt_cnv !== 1'b1 && n < 8) begin
      step(1);
      n++;
    end
    checks++;
    if (strt_cnv !== 1'b1) begin
      fails++;
      $display("FAIL conv_strt_wait: strt_cnv=%b expected 1 within 8 cycles", strt_cnv);
    end
    step(1);
    cnv_cmplt = 1'b1;
    res       = r;
    step(1);
    cnv_cmplt = 1'b0;
    n = 0;
    while (req_done !== 1'b1 && n < 4) begin
      step(1);
      n++;
    end
    checks++;
    if (req_done !== 1'b1) begin
      fails++;
      $display("FAIL conv_done_wait: req_done=%b expected 1 within 4 cycles", req_done);
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    req_cnv   = 1'b0;
    cnv_cmplt = 1'b0;
    res       = 12'h000;
    step(2);
    checks++;
    if ({strt_cnv, req_done, batt_vld, batt_low, a2d_fault} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: got %b expected 00000", {strt_cnv, req_done, batt_vld, batt_low, a2d_fault});
    end
    checks++;
    if ({batt_filt, batt} !== 20'h0) begin
      fails++;
      $display("FAIL reset_data: filt=%h batt=%h expected 000/00", batt_filt, batt);
    end
    rst = 1'b0;
  endtask

  task automatic test_demand;
    apply_reset();
    step(10);
    req_cnv = 1'b1;
    step(1);
    req_cnv = 1'b0;
    checks++;
    if (strt_cnv !== 1'b0) begin fails++; $display("FAIL demand_strt_t11: got %b expected 0", strt_cnv); end
    step(1);
    checks++;
    if (strt_cnv !== 1'b1) begin fails++; $display("FAIL demand_strt_t12: got %b expected 1", strt_cnv); end
    step(1);
    checks++;
    if (strt_cnv !== 1'b0) begin fails++; $display("FAIL demand_strt_t13: got %b expected 0", strt_cnv); end
    step(7);
    cnv_cmplt = 1'b1;
    res       = 12'hC00;
    step(1);
    cnv_cmplt = 1'b0;
    res       = 12'h000;
    checks++;
    if ({req_done, batt_vld} !== 2'b00) begin fails++; $display("FAIL demand_t21: done/vld=%b expected 00", {req_done, batt_vld}); end
    step(1);
    checks++;
    if (batt_filt !== 12'hC00) begin fails++; $display("FAIL demand_filt: got %h expected c00", batt_filt); end
    checks++;
    if (batt !== 8'hC0) begin fails++; $display("FAIL demand_batt: got %h expected c0", batt); end
    checks++;
    if ({req_done, batt_vld} !== 2'b11) begin fails++; $display("FAIL demand_t22: done/vld=%b expected 11", {req_done, batt_vld}); end
    step(1);
    checks++;
    if (req_done !== 1'b0) begin fails++; $display("FAIL demand_done_t23: got %b expected 0", req_done); end
  endtask

  task automatic test_filter;
    logic [11:0] exp_f [4] = '{12'hC00, 12'hB00, 12'hA40, 12'h9B0};
    logic [11:0] feed  [4] = '{12'hC00, 12'h800, 12'h800, 12'h800};
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      do_conv(feed[i]);
      checks++;
      if (batt_filt !== exp_f[i]) begin
        fails++;
        $display("FAIL filter_%0d: got %h expected %h", i, batt_filt, exp_f[i]);
      end
    end
    checks++;
    if (batt !== 8'h9B) begin fails++; $display("FAIL filter_batt: got %h expected 9b", batt); end
  endtask

  task automatic test_low_hyst;
    apply_reset();
    for (int i = 1; i <= 4; i++) begin
      do_conv(12'h900);
      checks++;
      if (batt_low !== ((i == 4) ? 1'b1 : 1'b0)) begin
        fails++;
        $display("FAIL low_sample_%0d: batt_low=%b expected %b", i, batt_low, (i == 4));
      end
    end
    // 900 -> 950 (still below threshold), -> A7C (band), -> BDC (recovered)
    do_conv(12'hA40);
    checks++;
    if ({batt_filt, batt_low} !== {12'h950, 1'b1}) begin
      fails++;
      $display("FAIL low_a40: filt=%h low=%b expected 950/1", batt_filt, batt_low);
    end
    do_conv(12'hE00);
    checks++;
    if ({batt_filt, batt_low} !== {12'hA7C, 1'b1}) begin
      fails++;
      $display("FAIL low_band: filt=%h low=%b expected a7c/1", batt_filt, batt_low);
    end
    do_conv(12'hFFF);
    checks++;
    if ({batt_filt, batt_low} !== {12'hBDC, 1'b0}) begin
      fails++;
      $display("FAIL low_recover: filt=%h low=%b expected bdc/0", batt_filt, batt_low);
    end
  endtask

  task automatic test_collision;
    int nstrt = 0;
    int ndone = 0;
    apply_reset();
    // Period expires in cycle 98; demand arrives in the same cycle.
    step(98);
    req_cnv = 1'b1;
    step(1);
    req_cnv = 1'b0;
    checks++;
    if (strt_cnv !== 1'b0) begin fails++; $display("FAIL coll_strt_t99: got %b expected 0", strt_cnv); end
    step(1);
    checks++;
    if (strt_cnv !== 1'b1) begin fails++; $display("FAIL coll_strt_t100: got %b expected 1", strt_cnv); end
    step(1);
    cnv_cmplt = 1'b1;
    res       = 12'hC00;
    step(1);
    cnv_cmplt = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (strt_cnv === 1'b1) nstrt++;
      if (req_done === 1'b1) ndone++;
      step(1);
    end
    checks++;
    if (nstrt !== 0) begin fails++; $display("FAIL coll_extra_strt: got %0d expected 0", nstrt); end
    checks++;
    if (ndone !== 1) begin fails++; $display("FAIL coll_done_count: got %0d expected 1", ndone); end
  endtask

  task automatic test_back_to_back;
    apply_reset();
    step(10);
    req_cnv = 1'b1;
    step(1);
    req_cnv = 1'b0;
    step(1);
    checks++;
    if (strt_cnv !== 1'b1) begin fails++; $display("FAIL b2b_strt1: got %b expected 1", strt_cnv); end
    step(1);
    cnv_cmplt = 1'b1;
    res       = 12'h800;
    req_cnv   = 1'b1;
    step(1);
    cnv_cmplt = 1'b0;
    req_cnv   = 1'b0;
    checks++;
    if (strt_cnv !== 1'b0) begin fails++; $display("FAIL b2b_strt_t14: got %b expected 0", strt_cnv); end
    step(1);
    checks++;
    if ({req_done, strt_cnv, batt_filt} !== {2'b10, 12'h800}) begin
      fails++;
      $display("FAIL b2b_t15: done=%b strt=%b filt=%h expected 1/0/800", req_done, strt_cnv, batt_filt);
    end
    step(1);
    checks++;
    if (strt_cnv !== 1'b1) begin fails++; $display("FAIL b2b_strt2_t16: got %b expected 1", strt_cnv); end
    step(1);
    cnv_cmplt = 1'b1;
    res       = 12'hC00;
    step(1);
    cnv_cmplt = 1'b0;
    step(1);
    checks++;
    if ({req_done, batt_filt} !== {1'b1, 12'h900}) begin
      fails++;
      $display("FAIL b2b_t19: done=%b filt=%h expected 1/900", req_done, batt_filt);
    end
  endtask

  task automatic test_timeout;
    apply_reset();
    step(10);
    req_cnv = 1'b1;
    step(1);
    req_cnv = 1'b0;
    step(1);
    checks++;
    if (strt_cnv !== 1'b1) begin fails++; $display("FAIL tmo_strt_t12: got %b expected 1", strt_cnv); end
    step(15);
    checks++;
    if ({a2d_fault, req_done} !== 2'b00) begin fails++; $display("FAIL tmo_t27: fault/done=%b expected 00", {a2d_fault, req_done}); end
    step(1);
    checks++;
    if ({a2d_fault, req_done} !== 2'b11) begin fails++; $display("FAIL tmo_t28: fault/done=%b expected 11", {a2d_fault, req_done}); end
    step(1);
    checks++;
    if ({a2d_fault, req_done} !== 2'b10) begin fails++; $display("FAIL tmo_t29: fault/done=%b expected 10", {a2d_fault, req_done}); end
    // Next periodic conversion: PERIOD cycles after the START at cycle 12.
    step(82);
    checks++;
    if (strt_cnv !== 1'b0) begin fails++; $display("FAIL tmo_auto_t111: got %b expected 0", strt_cnv); end
    step(1);
    checks++;
    if (strt_cnv !== 1'b1) begin fails++; $display("FAIL tmo_auto_t112: got %b expected 1", strt_cnv); end
    // This auto conversion also times out but was not demanded: no req_done.
    step(16);
    checks++;
    if ({a2d_fault, req_done} !== 2'b10) begin fails++; $display("FAIL tmo_auto_t128: fault/done=%b expected 10", {a2d_fault, req_done}); end
    apply_reset();
    checks++;
    if (a2d_fault !== 1'b0) begin fails++; $display("FAIL tmo_fault_cleared: got %b expected 0", a2d_fault); end
  endtask

  task automatic test_reset_mid_wait;
    int early = 0;
    apply_reset();
    do_conv(12'hC00);
    step(4);
    req_cnv = 1'b1;
    step(1);
    req_cnv = 1'b0;
    step(3);
    // Conversion is now in WAIT; reset asynchronously.
    rst = 1'b1;
    step(1);
    checks++;
    if ({strt_cnv, req_done, batt_vld, batt_low, a2d_fault} !== 5'b0) begin
      fails++;
      $display("FAIL rstw_flags: got %b expected 00000", {strt_cnv, req_done, batt_vld, batt_low, a2d_fault});
    end
    checks++;
    if ({batt_filt, batt} !== 20'h0) begin
      fails++;
      $display("FAIL rstw_data: filt=%h batt=%h expected 000/00", batt_filt, batt);
    end
    rst = 1'b0;
    step(2);
    cnv_cmplt = 1'b1;
    res       = 12'h123;
    step(1);
    cnv_cmplt = 1'b0;
    step(2);
    checks++;
    if ({req_done, batt_vld, batt_filt} !== {2'b00, 12'h000}) begin
      fails++;
      $display("FAIL rstw_late_cmplt: done=%b vld=%b filt=%h expected 0/0/000", req_done, batt_vld, batt_filt);
    end
    for (int i = 5; i < 100; i++) begin
      if (strt_cnv === 1'b1) early++;
      step(1);
    end
    checks++;
    if (early !== 0) begin fails++; $display("FAIL rstw_early_strt: got %0d expected 0", early); end
    checks++;
    if (strt_cnv !== 1'b1) begin fails++; $display("FAIL rstw_first_strt_t100: got %b expected 1", strt_cnv); end
  endtask

  initial begin
    test_reset();
    test_demand();
    test_filter();
    test_low_hyst();
    test_collision();
    test_back_to_back();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
